// File: rtl/rr_pkt_sched_pkg.sv
// Shared definitions for the round-robin packet scheduler: default port count
// and the scheduler FSM state encoding.
package rr_pkt_sched_pkg;

    localparam int IN_PORT_NUM = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_XFER  = 2'd2,
        ST_GAP   = 2'd3
    } sched_state_e;

endpackage

// File: rtl/rr_pkt_sched_if.sv
// Scheduler-side bundle: per-port requests, selected-path read status coming
// back from the mux, and the mux/read-control outputs.
interface rr_pkt_sched_if #(
    parameter int PORTS = rr_pkt_sched_pkg::IN_PORT_NUM
) ();
    localparam int SEL_W = $clog2(PORTS);

    logic [PORTS-1:0] i_req;
    logic             i_rd_vld;
    logic             i_rd_eop;
    logic             o_en;
    logic [SEL_W-1:0] o_sel;
    logic [PORTS-1:0] o_rd_start;
    logic             o_abort;
    logic             o_busy;

    modport slave (
        input  i_req, i_rd_vld, i_rd_eop,
        output o_en, o_sel, o_rd_start, o_abort, o_busy
    );

    modport master (
        output i_req, i_rd_vld, i_rd_eop,
        input  o_en, o_sel, o_rd_start, o_abort, o_busy
    );
endinterface

// File: rtl/rr_pkt_sched_find_first.sv
// Combinational round-robin search: first set request bit at or after ptr,
// wrapping past the top port back to port 0.
module rr_find_first #(
    parameter int N = 16,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         found
);
    logic [W:0]   sum_s;
    logic [W-1:0] cand_s;

    // Scan from the farthest offset down so the nearest hit to ptr wins.
    always_comb begin
        idx    = '0;
        found  = 1'b0;
        sum_s  = '0;
        cand_s = '0;
        for (int i = N - 1; i >= 0; i--) begin
            sum_s = {1'b0, ptr} + (W + 1)'(i);
            if (sum_s >= (W + 1)'(N)) begin
                sum_s = sum_s - (W + 1)'(N);
            end else begin
                sum_s = sum_s;
            end
            cand_s = sum_s[W-1:0];
            if (req[cand_s]) begin
                idx   = cand_s;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
    end
endmodule

// File: rtl/rr_pkt_sched.sv
// Round-robin packet scheduler: grants one whole packet at a time to the
// requesting input ports, with an idle-beat watchdog that aborts stalled packets.
module rr_pkt_sched #(
    parameter int IN_PORT_NUM = rr_pkt_sched_pkg::IN_PORT_NUM,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    rr_pkt_sched_if.slave  bus
);
    import rr_pkt_sched_pkg::*;

    localparam int SEL_W = $clog2(IN_PORT_NUM);
    localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);

    sched_state_e           state_q, state_d;
    logic [SEL_W-1:0]       ptr_q, ptr_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic [WD_W-1:0]        wd_q, wd_d;
    logic [IN_PORT_NUM-1:0] rd_start_q, rd_start_d;
    logic                   abort_q, abort_d;

    logic [SEL_W-1:0]       win_idx_s;
    logic                   win_found_s;
    logic                   eop_s;
    logic                   tmo_s;
    logic [SEL_W-1:0]       nxt_ptr_s;

    rr_find_first #(.N(IN_PORT_NUM), .W(SEL_W)) u_find_first (
        .req   (bus.i_req),
        .ptr   (ptr_q),
        .idx   (win_idx_s),
        .found (win_found_s)
    );

    // Packet-end conditions; the watchdog fires on the idle beat that brings it to TIMEOUT_CYC.
    always_comb begin
        eop_s     = bus.i_rd_vld & bus.i_rd_eop &
                    ((state_q == ST_GRANT) | (state_q == ST_XFER));
        tmo_s     = (state_q == ST_XFER) & ~bus.i_rd_vld &
                    (wd_q == WD_W'(TIMEOUT_CYC - 1));
        nxt_ptr_s = (sel_q == SEL_W'(IN_PORT_NUM - 1)) ? '0 : sel_q + SEL_W'(1);
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            sel_q      <= '0;
            wd_q       <= '0;
            rd_start_q <= '0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            sel_q      <= sel_d;
            wd_q       <= wd_d;
            rd_start_q <= rd_start_d;
            abort_q    <= abort_d;
        end
    end

    // Next-state, pointer, select and watchdog update.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        wd_d    = wd_q;
        case (state_q)
            ST_IDLE: begin
                wd_d = '0;
                if (win_found_s) begin
                    sel_d   = win_idx_s;
                    state_d = ST_GRANT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                wd_d = '0;
                if (eop_s) begin
                    ptr_d   = nxt_ptr_s;
                    state_d = ST_GAP;
                end else begin
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (eop_s) begin
                    wd_d    = '0;
                    ptr_d   = nxt_ptr_s;
                    state_d = ST_GAP;
                end else if (bus.i_rd_vld) begin
                    wd_d = '0;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                    if (tmo_s) begin
                        ptr_d   = nxt_ptr_s;
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_XFER;
                    end
                end
            end
            ST_GAP: begin
                wd_d    = '0;
                state_d = ST_IDLE;
            end
            default: begin
                wd_d    = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode: pulses for the registers, plus the state-decoded enable and busy.
    always_comb begin
        rd_start_d = '0;
        abort_d    = 1'b0;
        if ((state_q == ST_IDLE) && win_found_s) begin
            rd_start_d[win_idx_s] = 1'b1;
        end else begin
            rd_start_d = '0;
        end
        if (tmo_s && !eop_s) begin
            abort_d = 1'b1;
        end else begin
            abort_d = 1'b0;
        end
        bus.o_en   = (state_q == ST_GRANT) | (state_q == ST_XFER);
        bus.o_busy = (state_q != ST_IDLE);
    end

    assign bus.o_sel      = sel_q;
    assign bus.o_rd_start = rd_start_q;
    assign bus.o_abort    = abort_q;

endmodule
